// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_ctrl
// Purpose  : RAW hazard detection, load-use stall and EX operand forwarding
//            select for an in-order pipeline, with a saturating stall counter.
// Revision : 1.0
// ============================================================================
module hazard_fwd_ctrl #(
    parameter int AW     = 5,
    parameter int NSRC   = 2,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_rs,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic [AW-1:0]        ex_rd,
    input  logic                 ex_regwrite,
    input  logic                 ex_memread,
    input  logic [AW-1:0]        mem_rd,
    input  logic                 mem_regwrite,
    input  logic                 flush,
    output logic                 stall,
    output logic [2*NSRC-1:0]    fwd_sel,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic             c_fwd     = (FWD_EN != 0);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [NSRC-1:0]   w_match_ex;
    logic [NSRC-1:0]   w_match_mem;
    logic              w_hazard;
    logic              w_bubble;
    logic [2*NSRC-1:0] fwd_sel_d;
    logic [2*NSRC-1:0] fwd_sel_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    // A bubble goes into EX whenever ID is held or killed, so nothing forwards.
    assign w_bubble = stall | flush;

    generate
        for (genvar k = 0; k < NSRC; k++) begin : g_src
            logic [AW-1:0] w_rs;
            logic          w_live;
            logic          w_ex_alu;

            assign w_rs           = id_rs[k*AW +: AW];
            assign w_live         = id_valid & id_rs_used[k] & (w_rs != '0);
            assign w_match_ex[k]  = w_live & ex_regwrite  & (w_rs == ex_rd);
            assign w_match_mem[k] = w_live & mem_regwrite & (w_rs == mem_rd);
            assign w_ex_alu       = w_match_ex[k] & ~ex_memread;

            // EX producer wins over the older MEM producer.
            assign fwd_sel_d[2*k+1] = c_fwd & ~w_bubble & w_ex_alu;
            assign fwd_sel_d[2*k]   = c_fwd & ~w_bubble & ~w_ex_alu & w_match_mem[k];
        end
    endgenerate

    assign w_hazard = c_fwd ? ((|w_match_ex) & ex_memread)
                            : (|(w_match_ex | w_match_mem));

    assign stall = w_hazard & ~flush & ~reset;

    assign stall_cnt_d = (stall && (stall_cnt_q != c_cnt_max))
                       ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel   = fwd_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_fwd_ctrl
// Purpose  : Directed scoreboard bench for hazard_fwd_ctrl (three configs).
// Revision : 1.0
// ============================================================================
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, id_valid, ex_regwrite, ex_memread, mem_regwrite, flush;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  ex_rd, mem_rd;

    logic        stall0, stall1, stall2;
    logic [3:0]  fwd0, fwd1, fwd2;
    logic [15:0] cnt0, cnt1;
    logic [2:0]  cnt2;

    hazard_fwd_ctrl #(.AW(5), .NSRC(2), .FWD_EN(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .flush(flush), .stall(stall0), .fwd_sel(fwd0), .stall_cnt(cnt0));

    hazard_fwd_ctrl #(.AW(5), .NSRC(2), .FWD_EN(0), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .flush(flush), .stall(stall1), .fwd_sel(fwd1), .stall_cnt(cnt1));

    hazard_fwd_ctrl #(.AW(5), .NSRC(2), .FWD_EN(1), .CNT_W(3)) u_dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .flush(flush), .stall(stall2), .fwd_sel(fwd2), .stall_cnt(cnt2));

    typedef struct {
        string      nm;
        int         sel;
        logic       es;
        logic [3:0] ef;
        int         ec;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: each queued entry describes the outputs of the current cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin : mon
            exp_t        e;
            logic        as;
            logic [3:0]  af;
            logic [31:0] ac;
            e = exp_q.pop_front();
            case (e.sel)
                0:       begin as = stall0; af = fwd0; ac = {16'd0, cnt0}; end
                1:       begin as = stall1; af = fwd1; ac = {16'd0, cnt1}; end
                default: begin as = stall2; af = fwd2; ac = {29'd0, cnt2}; end
            endcase
            n_cmp = n_cmp + 3;
            if (as !== e.es) begin
                n_bad++;
                $display("FAIL %s.stall dut%0d: got %b want %b", e.nm, e.sel, as, e.es);
            end
            if (af !== e.ef) begin
                n_bad++;
                $display("FAIL %s.fwd_sel dut%0d: got %b want %b", e.nm, e.sel, af, e.ef);
            end
            if (ac !== e.ec) begin
                n_bad++;
                $display("FAIL %s.stall_cnt dut%0d: got %0d want %0d", e.nm, e.sel, ac, e.ec);
            end
        end
    end

    task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r0,
                       input logic [1:0] u, input logic [4:0] er, input logic erw,
                       input logic emr, input logic [4:0] mr, input logic mrw,
                       input logic fl, input logic rs);
        id_valid = v; id_rs = {r1, r0}; id_rs_used = u;
        ex_rd = er; ex_regwrite = erw; ex_memread = emr;
        mem_rd = mr; mem_regwrite = mrw; flush = fl; reset = rs;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input int sel, input logic es,
                       input logic [3:0] ef, input int ec);
        exp_t e;
        e.nm = nm; e.sel = sel; e.es = es; e.ef = ef; e.ec = ec;
        exp_q.push_back(e);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        tick(); tick();
        chk("rst0", 0, 0, 4'b0000, 0);
        chk("rst1", 1, 0, 4'b0000, 0);
        chk("rst2", 2, 0, 4'b0000, 0);

        // EX ALU and MEM both produce r2: EX has priority.
        drv(1, 3, 2, 2'b11, 2, 1, 0, 2, 1, 0, 0); chk("ex_prio_a", 0, 0, 4'b0000, 0);
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); chk("ex_prio_b", 0, 0, 4'b0010, 0);

        // Load-use on r5, then the load moves to MEM.
        drv(1, 0, 5, 2'b01, 5, 1, 1, 0, 0, 0, 0); chk("lduse_a", 0, 1, 4'b0000, 0);
        drv(1, 0, 5, 2'b01, 0, 0, 0, 5, 1, 0, 0); chk("lduse_b", 0, 0, 4'b0000, 1);
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); chk("lduse_c", 0, 0, 4'b0001, 1);

        // r0 never matches; unused sources never match.
        drv(1, 0, 0, 2'b01, 0, 1, 0, 0, 1, 0, 0); chk("r0_a", 0, 0, 4'b0000, 1);
        drv(1, 0, 7, 2'b00, 7, 1, 1, 7, 1, 0, 0); chk("unused_a", 0, 0, 4'b0000, 1);
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); chk("unused_b", 0, 0, 4'b0000, 1);

        // Load-use plus MEM match while flushing: no stall, bubble forwards nothing.
        drv(1, 9, 6, 2'b11, 6, 1, 1, 9, 1, 1, 0); chk("flush_a", 0, 0, 4'b0000, 1);
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); chk("flush_b", 0, 0, 4'b0000, 1);

        // Both sources forwarded from different stages.
        drv(1, 9, 6, 2'b11, 6, 1, 0, 9, 1, 0, 0); chk("two_src_a", 0, 0, 4'b0000, 1);
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); chk("two_src_b", 0, 0, 4'b0110, 1);

        // No-forwarding config: stall while MEM still produces r4.
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1); tick();
        drv(1, 4, 1, 2'b11, 0, 0, 0, 4, 1, 0, 0); chk("nofwd_a", 1, 1, 4'b0000, 0);
        drv(1, 4, 1, 2'b11, 0, 0, 0, 4, 1, 0, 0); chk("nofwd_b", 1, 1, 4'b0000, 1);
        drv(1, 4, 1, 2'b11, 0, 0, 0, 8, 1, 0, 0); chk("nofwd_c", 1, 0, 4'b0000, 2);
        drv(1, 4, 1, 2'b11, 1, 1, 0, 0, 0, 0, 0); chk("nofwd_ex", 1, 1, 4'b0000, 2);
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); chk("nofwd_d", 1, 0, 4'b0000, 3);

        // 3-bit counter saturates at 7 after 9 stall cycles.
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1); tick();
        for (int i = 0; i < 9; i++) begin
            drv(1, 0, 5, 2'b01, 5, 1, 1, 0, 0, 0, 0);
            chk("sat", 2, 1, 4'b0000, (i > 7) ? 7 : i);
        end
        drv(1, 0, 5, 2'b01, 5, 1, 0, 0, 0, 0, 0); chk("sat_held", 2, 0, 4'b0000, 7);
        // Reset while the hazard is present: stall suppressed, state cleared at the edge.
        drv(1, 0, 5, 2'b01, 5, 1, 1, 0, 0, 0, 1); chk("mid_rst_a", 2, 0, 4'b0010, 7);
        drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); chk("mid_rst_b", 2, 0, 4'b0000, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 5, register address width.
REQ-002 The block SHALL have parameter NSRC, default 2, source operands per instruction (1..4).
REQ-003 The block SHALL have parameter FWD_EN, default 1: 1 = forwarding plus load-use stall; 0 = no forwarding, stall on every RAW hazard.
REQ-004 The block SHALL have parameter CNT_W, default 16, stall counter width.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 The block SHALL have the following ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- id_valid  in  1  ID stage holds a live instruction.
- id_rs  in  NSRC*AW  ID source addresses; source k at bits [k*AW +: AW].
- id_rs_used  in  NSRC  bit k set = source k is read.
- ex_rd  in  AW  destination of the EX-stage instruction.
- ex_regwrite  in  1  EX instruction writes ex_rd.
- ex_memread  in  1  EX instruction is a load.
- mem_rd  in  AW  destination of the MEM-stage instruction.
- mem_regwrite  in  1  MEM instruction writes mem_rd.
- flush  in  1  kill the ID instruction (taken branch/jump).
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX (combinational).
- fwd_sel  out  2*NSRC  registered operand select for the EX-stage instruction, source k at [2k+1:2k]: 00 regfile, 10 from EX/MEM, 01 from MEM/WB.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-007 Hazard match for source k SHALL require id_valid, id_rs_used[k], id_rs[k] != 0, and equality with the producer rd whose regwrite is 1; register 0 never matches.
REQ-008 With FWD_EN=1, a hazard SHALL exist when any source k matches ex_rd with ex_memread=1.
REQ-009 With FWD_EN=0, a hazard SHALL exist when any source k matches ex_rd or mem_rd. The WB-stage producer is covered by the write-first register file.
REQ-010 stall SHALL equal hazard AND NOT flush AND NOT reset, within the same cycle.
REQ-011 fwd_sel SHALL be computed in ID from the current ex_*/mem_* inputs and registered, so it is valid in the following cycle when the instruction occupies EX. This gives 1-cycle latency from ID.
REQ-012 Per source k, with FWD_EN=1, the registered select SHALL be:
- 10 if source k matches ex_rd, ex_regwrite=1, ex_memread=0 (that producer is in EX/MEM next cycle);
- else 01 if source k matches mem_rd with mem_regwrite=1 (that producer is in MEM/WB next cycle);
- else 00.
EX match has priority over MEM match.
REQ-013 With FWD_EN=0, every fwd_sel field SHALL be registered as 00.
REQ-014 In a cycle with stall=1 or flush=1, fwd_sel SHALL be registered as all zeros, because a bubble enters EX.
REQ-015 After a load-use stall (FWD_EN=1), re-evaluation SHALL occur naturally on the next cycle: the load is now in MEM, so the dependent source registers 01.
REQ-016 stall_cnt SHALL increment by 1 on every clock edge where stall=1, and SHALL saturate at all-ones without wrapping.
REQ-017 flush and hazard in the same cycle SHALL give stall=0 and no stall_cnt increment.
REQ-018 Unused sources (id_rs_used[k]=0) SHALL never cause stall and SHALL register fwd_sel field k = 00.

Reset
REQ-019 On a clock edge with reset=1, fwd_sel SHALL become 0 and stall_cnt SHALL become 0.
REQ-020 stall SHALL be 0 throughout any cycle where reset=1.
REQ-021 Reset asserted mid-stall SHALL clear stall_cnt and fwd_sel at that edge, regardless of the other inputs.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- FWD_EN=1, id_rs={r3,r2}, used=11, ex_rd=r2 ALU write, mem_rd=r2 write -> stall=0; next cycle fwd_sel=0b0010 (src0=10, EX priority).
- FWD_EN=1, ex_rd=r5, ex_memread=1, id_rs src0=r5 -> stall=1, stall_cnt+1, next fwd_sel=0. Following cycle with ex bubble and mem_rd=r5 -> stall=0, then fwd_sel src0=01.
- id_rs src0=r0, ex_rd=r0 with regwrite -> stall=0, fwd_sel=00; same with id_rs_used[0]=0 and rd=r7 match -> no stall, 00.
- Load-use hazard with flush=1 -> stall=0, stall_cnt unchanged, next fwd_sel=0.
- FWD_EN=0, src1=r4 matches mem_rd=r4 -> stall=1 each cycle until mem_rd no longer matches; fwd_sel always 0.
- CNT_W=3, 9 consecutive stall cycles -> stall_cnt=7 held; reset=1 -> stall_cnt=0, fwd_sel=0, stall=0 that cycle.
